// File: rtl/pixel_sensor_pkg.sv
// pixel_sensor_pkg: phase encoding, phase ordering rule and default widths shared by the pixel sensor blocks
package pixel_sensor_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_PIX = 4;
  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} phase_t;
  function automatic phase_t next_legal_phase(input phase_t p);
    return (p == IDLE || p == READ) ? ERASE : phase_t'(p + 3'd1);
  endfunction
endpackage

// File: rtl/pixel_readout_fifo.sv
// pixel_readout_fifo: synchronous FIFO that buffers captured pixel words; reads as 0 when empty
module pixel_readout_fifo #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  assign full = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  // a write into a full FIFO is accepted only when a pop frees a slot in the same cycle
  always_comb begin
    rd = pop && !empty;
    wr = push && (!full || rd);
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(rd);
    count_d = count_q + CW'(wr) - CW'(rd);
  end
  // storage array, deliberately not reset
  always_ff @(posedge clk) if (wr) mem_q[wr_ptr_q] <= wr_data;
  // pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: tracks sensor phases, drives the conversion ramp and streams pixel words read back
module pixel_readout_ctrl
  import pixel_sensor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_PIX = DEF_N_PIX,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     erase,
  input  logic                     expose,
  input  logic                     convert,
  input  logic                     read,
  input  logic [DATA_W-1:0]        pix_data_in,
  output logic [DATA_W-1:0]        ramp_code,
  output logic                     ramp_oe,
  output logic [$clog2(N_PIX)-1:0] pix_sel,
  output logic                     pix_rd,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done,
  output logic                     seq_err,
  output logic                     overflow
);
  localparam int SW = $clog2(N_PIX);
  localparam int CW = $clog2(N_PIX + 1);
  phase_t phase_q, phase_d, strb_phase;
  logic [3:0] strb;
  logic [DATA_W-1:0] ramp_code_q, ramp_code_d;
  logic [SW-1:0] pix_sel_q, pix_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ramp_oe_q, ramp_oe_d, pix_rd_q, pix_rd_d, read_q, read_d;
  logic frame_done_q, frame_done_d, seq_err_q, seq_err_d, overflow_q, overflow_d;
  logic multi, early, start, more, push, pop, full, empty;
  assign ramp_code = ramp_code_q;
  assign ramp_oe = ramp_oe_q;
  assign pix_sel = pix_sel_q;
  assign pix_rd = pix_rd_q;
  assign frame_done = frame_done_q;
  assign seq_err = seq_err_q;
  assign overflow = overflow_q;
  assign out_valid = !empty;
  // next state for phase tracking, ramp, pixel addressing and the sticky flags
  always_comb begin
    strb = {read, convert, expose, erase};
    multi = (strb & (strb - 4'd1)) != 4'd0;
    strb_phase = read ? READ : convert ? CONVERT : expose ? EXPOSE : ERASE;
    start = read && !read_q;
    more = read && read_q && cnt_q < CW'(N_PIX);
    early = read_q && !read && cnt_q < CW'(N_PIX);
    push = pix_rd_q;
    pop = !empty && out_ready;
    phase_d = |strb ? strb_phase : phase_q;
    seq_err_d = seq_err_q || multi || early ||
                (|strb && strb_phase != phase_q && strb_phase != next_legal_phase(phase_q));
    ramp_oe_d = convert;
    ramp_code_d = (convert && ramp_oe_q) ? ramp_code_q + DATA_W'(!(&ramp_code_q)) : '0;
    read_d = read;
    pix_rd_d = start || more;
    pix_sel_d = more ? SW'(cnt_q) : '0;
    cnt_d = start ? CW'(1) : more ? cnt_q + CW'(1) : cnt_q;
    frame_done_d = push && pix_sel_q == SW'(N_PIX - 1);
    overflow_d = overflow_q || (push && full && !pop);
  end
  // control and output registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= IDLE;
      ramp_code_q <= '0;
      ramp_oe_q <= 1'b0;
      pix_sel_q <= '0;
      pix_rd_q <= 1'b0;
      cnt_q <= '0;
      read_q <= 1'b0;
      frame_done_q <= 1'b0;
      seq_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ramp_code_q <= ramp_code_d;
      ramp_oe_q <= ramp_oe_d;
      pix_sel_q <= pix_sel_d;
      pix_rd_q <= pix_rd_d;
      cnt_q <= cnt_d;
      read_q <= read_d;
      frame_done_q <= frame_done_d;
      seq_err_q <= seq_err_d;
      overflow_q <= overflow_d;
    end
  end
  pixel_readout_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wr_data(pix_data_in),
    .rd_data(out_data),
    .full(full),
    .empty(empty)
  );
endmodule
